// File: rtl/if_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage with the IF/ID pipeline register. Owns the PC,
//   keeps at most one request outstanding to instruction memory, parks one
//   response in a skid entry while decode is stalled, and drops wrong-path
//   responses after a redirect.
//
//   Optional feature macro: STATIC_BTFN_EN
//     defined   : static prediction. Backward conditional branches (opcode
//                 1100011 with instr[31]=1) and JAL (1101111) are predicted
//                 taken; the next fetch uses the branch/jump target and
//                 id_pred_taken is set for that instruction.
//     undefined : next fetch is always pc+4 and id_pred_taken stays 0.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   imem_req_valid/ready/addr     fetch request handshake, word-aligned address
//   imem_rsp_valid/data           single-cycle response, one per accepted request
//   stall_i                       decode cannot accept; IF/ID holds
//   redirect_valid/redirect_pc    control-flow correction, overrides stall_i
//   id_valid/instr/pc/pc_plus4    IF/ID register contents toward decode
//   id_pred_taken                 fetch continued at a predicted target
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_pred_taken
);

  // REQ: request on the bus; WAIT: response pending; HOLD: skid entry valid,
  // waiting for decode; DRAIN: a stale request is outstanding, its response
  // must be discarded.
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;           // address of the request being issued / awaited
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        skid_pred;

  logic [31:0] fetch_next_pc;
  logic        fetch_pred;

`ifdef STATIC_BTFN_EN
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic        is_bwd_branch;
  logic        is_jal;

  always_comb begin
    b_imm = {{20{imem_rsp_data[31]}}, imem_rsp_data[7], imem_rsp_data[30:25],
             imem_rsp_data[11:8], 1'b0};
    j_imm = {{12{imem_rsp_data[31]}}, imem_rsp_data[19:12], imem_rsp_data[20],
             imem_rsp_data[30:21], 1'b0};
    is_bwd_branch = (imem_rsp_data[6:0] == 7'b1100011) && imem_rsp_data[31];
    is_jal        = (imem_rsp_data[6:0] == 7'b1101111);
    fetch_pred    = is_bwd_branch || is_jal;
    if (is_bwd_branch)   fetch_next_pc = pc + b_imm;
    else if (is_jal)     fetch_next_pc = pc + j_imm;
    else                 fetch_next_pc = pc + 32'd4;
  end
`else
  assign fetch_next_pc = pc + 32'd4;
  assign fetch_pred    = 1'b0;
`endif

  // NOTE: the request is gated by rst directly so nothing is issued while
  // reset is held, yet the first request appears the moment reset drops.
  assign imem_req_valid = (state == REQ) && !rst;
  assign imem_req_addr  = pc;

  // NOTE: every register below is written with <= so all of them update from
  // the same pre-edge values; a blocking write here would leak new state into
  // later decisions in the same block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= REQ;
      pc            <= RESET_PC;
      id_valid      <= 1'b0;
      id_instr      <= NOP_INSTR;
      id_pc         <= RESET_PC;
      id_pc_plus4   <= RESET_PC + 32'd4;
      id_pred_taken <= 1'b0;
      skid_instr    <= NOP_INSTR;
      skid_pc       <= RESET_PC;
      skid_pred     <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over stall: flush IF/ID and the skid (leaving HOLD
      // empties it), restart at the aligned target.
      pc       <= redirect_pc & ~32'h3;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      case (state)
        REQ:     state <= imem_req_ready ? DRAIN : REQ;
        WAIT:    state <= imem_rsp_valid ? REQ : DRAIN;
        HOLD:    state <= REQ;
        DRAIN:   state <= imem_rsp_valid ? REQ : DRAIN;
        default: state <= REQ;
      endcase
    end else begin
      // Default when decode advances: bubble, overridden below by a new entry.
      if (!stall_i) begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
      case (state)
        REQ: begin
          if (imem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            pc <= fetch_next_pc;
            if (!stall_i) begin
              id_valid      <= 1'b1;
              id_instr      <= imem_rsp_data;
              id_pc         <= pc;
              id_pc_plus4   <= pc + 32'd4;
              id_pred_taken <= fetch_pred;
              state         <= REQ;
            end else begin
              skid_instr <= imem_rsp_data;
              skid_pc    <= pc;
              skid_pred  <= fetch_pred;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            id_valid      <= 1'b1;
            id_instr      <= skid_instr;
            id_pc         <= skid_pc;
            id_pc_plus4   <= skid_pc + 32'd4;
            id_pred_taken <= skid_pred;
            state         <= REQ;
          end
        end
        DRAIN: begin
          if (imem_rsp_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_if_stage
//   Randomized bench for if_stage. A memory responder with random latency
//   answers accepted requests; the reference model walks the program as an
//   architectural PC (next address from the instruction's ISA meaning, or the
//   redirect target) and compares every instruction decode consumes.
//   Build with +define+STATIC_BTFN_EN to match an RTL built the same way.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          NUM_CYCLES = 3000;
  localparam int          DIRECTED_CYCLES = 40;

`ifdef STATIC_BTFN_EN
  localparam bit BTFN = 1'b1;
`else
  localparam bit BTFN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_pred_taken;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_pred_taken  (id_pred_taken)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // Instruction memory: a pure function of the word address.
  logic [31:0] mem [64];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return mem[addr[7:2]];
  endfunction

  // Architectural next PC from the instruction's meaning, using plain integer
  // weights of the immediate fields.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             output logic taken);
    int offs;
    taken = 1'b0;
    offs  = 4;
    if (BTFN && ins[6:0] == 7'b1100011 && ins[31]) begin
      offs  = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048 - 4096;
      taken = 1'b1;
    end else if (BTFN && ins[6:0] == 7'b1101111) begin
      offs  = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
              - (ins[31] ? (1 << 20) : 0);
      taken = 1'b1;
    end
    return pc + 32'(offs);
  endfunction

  // Reference state
  logic [31:0] exp_pc;
  int          delivered;
  int          cyc;

  // Memory responder state
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  // Previous-cycle observations
  bit          prev_unaccepted;
  logic [31:0] prev_addr;
  bit          prev_redirect;
  logic [31:0] prev_target;
  bit          prev_hold;
  logic [31:0] prev_id_pc;
  logic [31:0] prev_id_instr;

  // One cycle: decide this cycle's inputs, check outputs, advance the model.
  // Called #1 after a rising edge; the next rising edge consumes the inputs.
  task automatic step();
    bit          rsp_now;
    bit          hs;
    bit          directed;
    logic [31:0] word;
    logic [31:0] nxt;
    logic        tk;

    directed = (cyc < DIRECTED_CYCLES);

    // Response for a previously accepted request
    rsp_now        = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        rsp_now        = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
      end
    end

    if (directed) begin
      stall_i        = (cyc >= 8 && cyc <= 11);
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_req_ready = 1'b1;
    end else begin
      stall_i        = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           redirect_pc = $urandom & 32'h0000_01FF;
      imem_req_ready = ($urandom_range(0, 3) != 0);
    end

    // Checks carried over from the previous cycle
    if (prev_unaccepted) begin
      check("req_held_valid", {31'b0, imem_req_valid}, 32'd1);
      check("req_held_addr", imem_req_addr, prev_addr);
    end
    if (prev_redirect) begin
      check("redirect_flush_valid", {31'b0, id_valid}, 32'd0);
      if (imem_req_valid) check("redirect_req_addr", imem_req_addr, prev_target);
    end
    if (prev_hold) begin
      check("stall_hold_valid", {31'b0, id_valid}, 32'd1);
      check("stall_hold_pc", id_pc, prev_id_pc);
      check("stall_hold_instr", id_instr, prev_id_instr);
    end

    // Per-cycle invariants
    if (imem_req_valid) check("req_addr_aligned", {30'b0, imem_req_addr[1:0]}, 32'd0);
    if (!id_valid) check("bubble_instr", id_instr, NOP);

    // Decode consumes the IF/ID entry at this edge
    if (id_valid && !stall_i) begin
      word = mem_word(exp_pc);
      nxt  = model_next(exp_pc, word, tk);
      check("id_pc", id_pc, exp_pc);
      check("id_instr", id_instr, word);
      check("id_pc_plus4", id_pc_plus4, exp_pc + 32'd4);
      check("id_pred_taken", {31'b0, id_pred_taken}, {31'b0, tk});
      exp_pc = nxt;
      delivered++;
    end

    if (redirect_valid) exp_pc = redirect_pc & ~32'h3;

    // Request handshake at this edge
    hs = imem_req_valid && imem_req_ready;
    if (hs) begin
      check("single_outstanding", {31'b0, pend || rsp_now}, 32'd0);
      pend      = 1'b1;
      pend_cnt  = directed ? 1 : $urandom_range(1, 3);
      pend_addr = imem_req_addr;
    end

    prev_unaccepted = imem_req_valid && !imem_req_ready && !redirect_valid;
    prev_addr       = imem_req_addr;
    prev_redirect   = redirect_valid;
    prev_target     = redirect_pc & ~32'h3;
    prev_hold       = id_valid && stall_i && !redirect_valid;
    prev_id_pc      = id_pc;
    prev_id_instr   = id_instr;
    cyc++;
  endtask

  initial begin
    logic [31:0] w;
    logic [6:0]  op;

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      case ($urandom_range(0, 7))
        0, 1:    op = 7'b1100011;
        2:       op = 7'b1101111;
        default: op = 7'b0010011;
      endcase
      w[6:0] = op;
      mem[i] = w;
    end
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = NOP;
    mem[3] = NOP;
    mem[4] = 32'hFE00_0EE3;   // beq -4 at 0x10

    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    stall_i        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    exp_pc         = 32'h0;
    delivered      = 0;
    cyc            = 0;
    pend           = 1'b0;
    pend_cnt       = 0;
    pend_addr      = 32'h0;
    prev_unaccepted = 1'b0;
    prev_addr       = 32'h0;
    prev_redirect   = 1'b0;
    prev_target     = 32'h0;
    prev_hold       = 1'b0;
    prev_id_pc      = 32'h0;
    prev_id_instr   = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_id_instr", id_instr, NOP);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_pc_plus4", id_pc_plus4, 32'h4);
    check("rst_id_pred", {31'b0, id_pred_taken}, 32'd0);

    rst = 1'b0;
    #1;
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);

    step();
    repeat (NUM_CYCLES) begin
      @(posedge clk);
      #1;
      step();
    end

    check("forward_progress", {31'b0, delivered >= 100}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
